// File: rtl/sgpio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sgpio_pkg
//  Description : Shared constants and state encoding for the SGPIO target
//                receiver (per-drive bit layout, FSM states, counter widths).
//  Revision    : 1.0  initial release
// ============================================================================
package sgpio_pkg;

    // Each drive occupies three consecutive frame bits: ACT, LOC, FAIL
    localparam int BITS_PER_DRIVE = 3;
    localparam int ACT_OFS        = 0;
    localparam int LOC_OFS        = 1;
    localparam int FAIL_OFS       = 2;

    // Width of the saturating short-frame counter
    localparam int ERR_CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } sgpio_state_e;

endpackage : sgpio_pkg
`default_nettype wire

// File: rtl/sgpio_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sgpio_sync_edge
//  Description : Two-flop synchroniser for an asynchronous input, with an
//                optional rising-edge detector on the synchronised value.
//                EDGE_EN=0 builds the synchroniser only (rise tied low).
//  Revision    : 1.0  initial release
// ============================================================================
module sgpio_sync_edge #(
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic meta_q;
    logic sync_q;

    // Two-stage synchroniser into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

    generate
        if (EDGE_EN) begin : g_edge
            logic prev_q;

            // Delayed copy of the synchronised value for edge detection
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_q <= 1'b0;
                end else begin
                    prev_q <= sync_q;
                end
            end

            assign rise = sync_q & ~prev_q;
        end else begin : g_no_edge
            assign rise = 1'b0;
        end
    endgenerate

endmodule : sgpio_sync_edge
`default_nettype wire

// File: rtl/sgpio_rx_multi.sv
`default_nettype none
// ============================================================================
//  Module      : sgpio_rx_multi
//  Description : SGPIO (SFF-8485) target receiver. Decodes ACT/LOC/FAIL for
//                NUM_DRIVES drives, checks frame length, watches for link
//                loss and counts short frames.
//                Optional macro SGPIO_ACT_STRETCH_EN: per-drive activity
//                stretch counters holding the ACT LED on for STRETCH_CYCLES.
//  Revision    : 1.0  initial release
// ============================================================================
module sgpio_rx_multi
    import sgpio_pkg::*;
#(
    parameter int          NUM_DRIVES     = 36,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000,
    parameter logic [19:0] STRETCH_CYCLES = 20'd1_000_000
) (
    input  logic                  SYSCLK,
    input  logic                  RESET_N,
    input  logic                  SCLK,
    input  logic                  SLOAD,
    input  logic                  SDOUT,
    output logic [NUM_DRIVES-1:0] ACT_LED_L,
    output logic [NUM_DRIVES-1:0] LOC,
    output logic [NUM_DRIVES-1:0] FAIL,
    output logic                  LINK_UP,
    output logic                  FRAME_STB,
    output logic [ERR_CNT_W-1:0]  FRAME_ERR_CNT
);

    localparam int               FRAME_BITS = BITS_PER_DRIVE * NUM_DRIVES;
    localparam int               CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [23:0]      WD_LAST    = TIMEOUT_CYCLES - 24'd1;

    // ------------------------------------------------------------------
    // Input synchronisation
    // ------------------------------------------------------------------
    logic sclk_rise;
    logic sload_s;
    logic sdout_s;
    logic sclk_sync_unused;
    logic sload_rise_unused;
    logic sdout_rise_unused;

    sgpio_sync_edge #(.EDGE_EN(1'b1)) u_sync_sclk (
        .clk   (SYSCLK),
        .rst_n (RESET_N),
        .d     (SCLK),
        .q     (sclk_sync_unused),
        .rise  (sclk_rise)
    );

    sgpio_sync_edge #(.EDGE_EN(1'b0)) u_sync_sload (
        .clk   (SYSCLK),
        .rst_n (RESET_N),
        .d     (SLOAD),
        .q     (sload_s),
        .rise  (sload_rise_unused)
    );

    sgpio_sync_edge #(.EDGE_EN(1'b0)) u_sync_sdout (
        .clk   (SYSCLK),
        .rst_n (RESET_N),
        .d     (SDOUT),
        .q     (sdout_s),
        .rise  (sdout_rise_unused)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    sgpio_state_e          state_q,  state_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic [FRAME_BITS-1:0] shift_q,  shift_d;
    logic [NUM_DRIVES-1:0] act_q,    act_d;
    logic [NUM_DRIVES-1:0] loc_q,    loc_d;
    logic [NUM_DRIVES-1:0] fail_q,   fail_d;
    logic                  link_q,   link_d;
    logic                  stb_q,    stb_d;
    logic [ERR_CNT_W-1:0]  err_q,    err_d;
    logic [23:0]           wd_q,     wd_d;

    logic [NUM_DRIVES-1:0] frame_act;
    logic [NUM_DRIVES-1:0] frame_loc;
    logic [NUM_DRIVES-1:0] frame_fail;
    logic                  timeout;
    logic                  commit;

    // Slice the completed shift register into per-drive fields (bit 0 is
    // the first bit received, which ends up at the LSB after FRAME_BITS shifts)
    always_comb begin
        frame_act  = '0;
        frame_loc  = '0;
        frame_fail = '0;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            frame_act[i]  = shift_q[BITS_PER_DRIVE*i + ACT_OFS];
            frame_loc[i]  = shift_q[BITS_PER_DRIVE*i + LOC_OFS];
            frame_fail[i] = shift_q[BITS_PER_DRIVE*i + FAIL_OFS];
        end
    end

    // Link-loss watchdog: fires once after TIMEOUT_CYCLES without an SCLK edge
    assign timeout = ~sclk_rise & (wd_q == WD_LAST);

    // Next-state, frame assembly, commit and watchdog logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        act_d   = act_q;
        loc_d   = loc_q;
        fail_d  = fail_q;
        link_d  = link_q;
        stb_d   = 1'b0;
        err_d   = err_q;
        wd_d    = wd_q;
        commit  = 1'b0;

        if (sclk_rise) begin
            wd_d = '0;
        end else if (wd_q != TIMEOUT_CYCLES) begin
            wd_d = wd_q + 24'd1;
        end

        case (state_q)
            IDLE, HOLD: begin
                // Wait for a frame start; extra bits of a long vector are dropped
                if (sclk_rise && sload_s) begin
                    shift_d = {sdout_s, {(FRAME_BITS-1){1'b0}}};
                    count_d = CNT_ONE;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (count_q == CNT_FULL) begin
                    commit  = 1'b1;
                    state_d = HOLD;
                end else if (sclk_rise) begin
                    if (sload_s) begin
                        // Short frame: restart with this bit as the new bit 0
                        shift_d = {sdout_s, {(FRAME_BITS-1){1'b0}}};
                        count_d = CNT_ONE;
                        if (err_q != {ERR_CNT_W{1'b1}}) begin
                            err_d = err_q + 1'b1;
                        end
                    end else begin
                        shift_d = {sdout_s, shift_q[FRAME_BITS-1:1]};
                        count_d = count_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            act_d  = frame_act;
            loc_d  = frame_loc;
            fail_d = frame_fail;
            link_d = 1'b1;
            stb_d  = 1'b1;
        end

        // Link loss overrides everything except the error count
        if (timeout) begin
            state_d = IDLE;
            count_d = '0;
            act_d   = '0;
            loc_d   = '0;
            fail_d  = '0;
            link_d  = 1'b0;
            stb_d   = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            count_q <= '0;
            shift_q <= '0;
            act_q   <= '0;
            loc_q   <= '0;
            fail_q  <= '0;
            link_q  <= 1'b0;
            stb_q   <= 1'b0;
            err_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
            act_q   <= act_d;
            loc_q   <= loc_d;
            fail_q  <= fail_d;
            link_q  <= link_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

`ifdef SGPIO_ACT_STRETCH_EN
    logic [19:0] stretch_q [NUM_DRIVES];
    logic [19:0] stretch_d [NUM_DRIVES];

    // Per-drive activity stretch: reload on an active commit, count down otherwise
    always_comb begin
        for (int i = 0; i < NUM_DRIVES; i++) begin
            stretch_d[i] = stretch_q[i];
            if (timeout) begin
                stretch_d[i] = '0;
            end else if (commit && frame_act[i]) begin
                stretch_d[i] = STRETCH_CYCLES;
            end else if (stretch_q[i] != '0) begin
                stretch_d[i] = stretch_q[i] - 20'd1;
            end
        end
    end

    // Stretch counter registers
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_DRIVES; i++) begin
                stretch_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DRIVES; i++) begin
                stretch_q[i] <= stretch_d[i];
            end
        end
    end

    // LED is lit while the committed bit is set or the stretch is running
    always_comb begin
        ACT_LED_L = '1;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            ACT_LED_L[i] = ~(act_q[i] | (stretch_q[i] != '0));
        end
    end
`else
    assign ACT_LED_L = ~act_q;
`endif

    assign LOC           = loc_q;
    assign FAIL          = fail_q;
    assign LINK_UP       = link_q;
    assign FRAME_STB     = stb_q;
    assign FRAME_ERR_CNT = err_q;

endmodule : sgpio_rx_multi
`default_nettype wire
